// File: rtl/paint_pkg.sv
// paint_pkg: shared types and constants for the paint sequencer
package paint_pkg;
    localparam int DEF_GRID_W = 8;
    localparam int DEF_GRID_H = 8;
    localparam int COORD_W    = 10;
    typedef enum logic [1:0] {OP_PIXEL, OP_STAMP, OP_CLEAR, OP_NOP} op_t;
    typedef enum logic [1:0] {IDLE, PIXEL, STAMP, CLEAR} state_t;
endpackage

// File: rtl/xy_sweeper.sv
// xy_sweeper: row-major 2-D counter; cur_x/cur_y is the cell emitted at the coming edge
// ports: start/step advance, bound_x/bound_y sweep size, org_x/org_y 11-bit origin,
//        cur_x/cur_y next cell, last = the cell currently held is the final one
module xy_sweeper
    import paint_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [COORD_W-1:0] bound_x,
    input  logic [COORD_W-1:0] bound_y,
    input  logic [COORD_W:0]   org_x,
    input  logic [COORD_W:0]   org_y,
    output logic [COORD_W:0]   cur_x,
    output logic [COORD_W:0]   cur_y,
    output logic               last
);
    logic [COORD_W-1:0] cx, cy, nx, ny;
    logic wrap;
    always_comb begin
        wrap  = cx == bound_x - 1'b1;
        last  = wrap && cy == bound_y - 1'b1;
        nx    = (start || wrap) ? '0 : cx + 1'b1;
        ny    = start ? '0 : wrap ? cy + 1'b1 : cy;
        cur_x = org_x + {1'b0, nx};
        cur_y = org_y + {1'b0, ny};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (start || step) begin
            cx <= nx;
            cy <= ny;
        end
    end
endmodule

// File: rtl/paint_sequencer.sv
// paint_sequencer: expands pixel/stamp/clear commands into one pixel-store write per cycle
// ports: cmd_* valid/ready command input; brush/ready/wx/wy/newColor store write port;
//        busy high on write cycles, done pulses the cycle after a command's last write
module paint_sequencer
    import paint_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [2:0]         cmd_color,
    output logic               brush,
    output logic               ready,
    output logic [COORD_W-1:0] wx,
    output logic [COORD_W-1:0] wy,
    output logic [2:0]         newColor,
    output logic               busy,
    output logic               done
);
    state_t state, state_n;
    op_t op;
    logic accept, load_px, start, sweep, step, finish, emit, is_clear, in_range, sw_last;
    logic [COORD_W-1:0] bx, by;
    logic [COORD_W:0] ox, oy, org_x, org_y, cur_x, cur_y, cell_x, cell_y;
    assign op        = op_t'(cmd_op);
    assign cmd_ready = state == IDLE && !reset;
    assign accept    = cmd_valid && cmd_ready;
    xy_sweeper u_sweep (
        .clk(clk), .reset(reset), .start(start), .step(step),
        .bound_x(bx), .bound_y(by), .org_x(org_x), .org_y(org_y),
        .cur_x(cur_x), .cur_y(cur_y), .last(sw_last)
    );
    always_comb begin
        load_px  = accept && op == OP_PIXEL;
        start    = accept && (op == OP_STAMP || op == OP_CLEAR);
        sweep    = state == STAMP || state == CLEAR;
        step     = sweep && !sw_last;
        finish   = state == PIXEL || (sweep && sw_last);
        emit     = load_px || start || step;
        is_clear = state == IDLE ? op == OP_CLEAR : state == CLEAR;
        bx       = is_clear ? COORD_W'(GRID_W) : COORD_W'(3);
        by       = is_clear ? COORD_W'(GRID_H) : COORD_W'(3);
        // stamp origin is one cell up-left of the target; negative values wrap into the 11-bit space
        org_x    = state != IDLE ? ox : is_clear ? '0 : {1'b0, cmd_x} - 1'b1;
        org_y    = state != IDLE ? oy : is_clear ? '0 : {1'b0, cmd_y} - 1'b1;
        cell_x   = load_px ? {1'b0, cmd_x} : cur_x;
        cell_y   = load_px ? {1'b0, cmd_y} : cur_y;
        // unsigned compare also rejects negative cells (MSB set)
        in_range = cell_x < (COORD_W+1)'(GRID_W) && cell_y < (COORD_W+1)'(GRID_H);
        state_n  = finish ? IDLE : load_px ? PIXEL : start ? (op == OP_CLEAR ? CLEAR : STAMP) : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            brush    <= 1'b0;
            ready    <= 1'b0;
            wx       <= '0;
            wy       <= '0;
            newColor <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ox       <= '0;
            oy       <= '0;
        end else begin
            state <= state_n;
            brush <= emit && in_range;
            ready <= emit && in_range;
            busy  <= emit;
            done  <= finish || (accept && op == OP_NOP);
            if (emit) begin
                wx <= cell_x[COORD_W-1:0];
                wy <= cell_y[COORD_W-1:0];
            end
            if (load_px || start) begin
                newColor <= cmd_color;
                ox       <= org_x;
                oy       <= org_y;
            end
        end
    end
endmodule
